// File: rtl/rbi_ring_req_arb.sv
// -----------------------------------------------------------------------------
// rbi_ring_req_arb
//
// Ring stop that shares one ringbus injection point between two local
// requesters (port 0 and port 1). Each cycle the incoming ring slot is one of:
//   EMPTY  - opm[7:0] == 0
//   MINE_n - a response (opm[7:6] == 2'b01) tagged with port n's node id
//   PASS   - anything else
// A PASS slot is forwarded unchanged. EMPTY and MINE slots are free. The
// round-robin arbiter may fill a free slot with one local request. A MINE_n
// slot is also handed to port n as a one-cycle response strobe.
//
// Each port has its own 8-bit sequence tag counter and its own limit on
// outstanding requests. A wait counter per port raises deadlockStrobe when a
// valid request has not been accepted for STARVE_LIM cycles.
//
// Ports
//   clock, reset        clock; synchronous active-high reset
//   unitNodeId[7:0]     base node id (bit0 = 0); port0 = id, port1 = id | 1
//   mem*In              ring input slot (seq/opm/addr/data)
//   mem*Out             ring output slot, registered, 1-cycle latency
//   reqValid/reqReady   per-port request handshake (ready is combinational)
//   reqOpm/Addr/Data    per-port request payload
//   rspValid            per-port one-cycle response strobe (registered)
//   rspSeq/Opm/Addr/Data per-port response message (registered)
//   deadlockStrobe      a port has waited STARVE_LIM cycles (registered)
// -----------------------------------------------------------------------------
module rbi_ring_req_arb #(
    parameter int MAX_OUTST  = 4,
    parameter int STARVE_LIM = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         unitNodeId,
    input  logic [15:0]        memSeqIn,
    input  logic [15:0]        memOpmIn,
    input  logic [47:0]        memAddrIn,
    input  logic [127:0]       memDataIn,
    output logic [15:0]        memSeqOut,
    output logic [15:0]        memOpmOut,
    output logic [47:0]        memAddrOut,
    output logic [127:0]       memDataOut,
    input  logic [1:0]         reqValid,
    output logic [1:0]         reqReady,
    input  logic [1:0][15:0]   reqOpm,
    input  logic [1:0][47:0]   reqAddr,
    input  logic [1:0][127:0]  reqData,
    output logic [1:0]         rspValid,
    output logic [1:0][15:0]   rspSeq,
    output logic [1:0][15:0]   rspOpm,
    output logic [1:0][47:0]   rspAddr,
    output logic [1:0][127:0]  rspData,
    output logic               deadlockStrobe
);

    localparam logic [3:0] MAX_O    = 4'(MAX_OUTST);
    localparam logic [7:0] STARVE_L = 8'(STARVE_LIM);

    // Tag 8'h00 is never issued, so the counter wraps from 8'hFF to 8'h01.
    function automatic logic [7:0] next_tag(input logic [7:0] tag);
        logic [7:0] nxt;
        if (tag == 8'hFF) begin
            nxt = 8'h01;
        end else begin
            nxt = tag + 8'h01;
        end
        return nxt;
    endfunction

    // ---------------------------------------------------------------- state
    logic [15:0]        ring_seq_q,  ring_seq_d;
    logic [15:0]        ring_opm_q,  ring_opm_d;
    logic [47:0]        ring_addr_q, ring_addr_d;
    logic [127:0]       ring_data_q, ring_data_d;
    logic [1:0]         rsp_valid_q, rsp_valid_d;
    logic [1:0][15:0]   rsp_seq_q,   rsp_seq_d;
    logic [1:0][15:0]   rsp_opm_q,   rsp_opm_d;
    logic [1:0][47:0]   rsp_addr_q,  rsp_addr_d;
    logic [1:0][127:0]  rsp_data_q,  rsp_data_d;
    logic [1:0][7:0]    seq_ctr_q,   seq_ctr_d;
    logic [1:0][3:0]    outst_q,     outst_d;
    logic [1:0][7:0]    wait_q,      wait_d;
    logic               rr_q,        rr_d;
    logic               deadlock_q,  deadlock_d;

    // ------------------------------------------------------------ decoding
    logic [1:0][7:0]    port_id_s;
    logic               slot_empty_s;
    logic [1:0]         slot_mine_s;
    logic               slot_free_s;
    logic [1:0]         eligible_s;
    logic               gnt_valid_s;
    logic               gnt_idx_s;
    logic [1:0]         accept_s;

    assign port_id_s[0] = unitNodeId;
    assign port_id_s[1] = unitNodeId | 8'h01;

    // Classify the incoming slot and find which ports may compete for it.
    always_comb begin
        slot_empty_s = (memOpmIn[7:0] == 8'h00);
        for (int n = 0; n < 2; n++) begin
            slot_mine_s[n] = (memOpmIn[7:6] == 2'b01) && (memSeqIn[15:8] == port_id_s[n]);
            eligible_s[n]  = reqValid[n] && (outst_q[n] < MAX_O);
        end
        // A response we consume leaves its slot free for injection.
        slot_free_s = slot_empty_s || (slot_mine_s != 2'b00);
    end

    // Round-robin grant between eligible ports; only in a free slot, never in reset.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_idx_s   = 1'b0;
        case (eligible_s)
            2'b01: begin
                gnt_valid_s = 1'b1;
                gnt_idx_s   = 1'b0;
            end
            2'b10: begin
                gnt_valid_s = 1'b1;
                gnt_idx_s   = 1'b1;
            end
            2'b11: begin
                gnt_valid_s = 1'b1;
                gnt_idx_s   = rr_q;
            end
            default: begin
                gnt_valid_s = 1'b0;
                gnt_idx_s   = 1'b0;
            end
        endcase
        if (!slot_free_s || reset) begin
            gnt_valid_s = 1'b0;
        end else begin
            gnt_valid_s = gnt_valid_s;
        end
        if (!gnt_valid_s) begin
            accept_s = 2'b00;
        end else if (gnt_idx_s) begin
            accept_s = 2'b10;
        end else begin
            accept_s = 2'b01;
        end
    end

    assign reqReady = accept_s;

    // Next ring output slot: injected request, forwarded PASS slot, or empty.
    always_comb begin
        ring_seq_d  = 16'h0000;
        ring_opm_d  = 16'h0000;
        ring_addr_d = 48'h0;
        ring_data_d = 128'h0;
        if (gnt_valid_s) begin
            ring_seq_d  = {port_id_s[gnt_idx_s], seq_ctr_q[gnt_idx_s]};
            ring_opm_d  = reqOpm[gnt_idx_s];
            ring_addr_d = reqAddr[gnt_idx_s];
            ring_data_d = reqData[gnt_idx_s];
        end else if (!slot_free_s) begin
            ring_seq_d  = memSeqIn;
            ring_opm_d  = memOpmIn;
            ring_addr_d = memAddrIn;
            ring_data_d = memDataIn;
        end else begin
            ring_seq_d  = 16'h0000;
            ring_opm_d  = 16'h0000;
            ring_addr_d = 48'h0;
            ring_data_d = 128'h0;
        end
    end

    // Per-port response capture, tag counters, outstanding and wait counters.
    always_comb begin
        rsp_valid_d = 2'b00;
        rsp_seq_d   = rsp_seq_q;
        rsp_opm_d   = rsp_opm_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;
        seq_ctr_d   = seq_ctr_q;
        outst_d     = outst_q;
        wait_d      = wait_q;
        for (int n = 0; n < 2; n++) begin
            if (slot_mine_s[n]) begin
                rsp_valid_d[n] = 1'b1;
                rsp_seq_d[n]   = memSeqIn;
                rsp_opm_d[n]   = memOpmIn;
                rsp_addr_d[n]  = memAddrIn;
                rsp_data_d[n]  = memDataIn;
            end else begin
                rsp_valid_d[n] = 1'b0;
            end

            if (accept_s[n]) begin
                seq_ctr_d[n] = next_tag(seq_ctr_q[n]);
            end else begin
                seq_ctr_d[n] = seq_ctr_q[n];
            end

            // A response for an already-empty count is ignored (stale tag).
            case ({accept_s[n], slot_mine_s[n]})
                2'b10: outst_d[n] = outst_q[n] + 4'd1;
                2'b01: begin
                    if (outst_q[n] != 4'd0) begin
                        outst_d[n] = outst_q[n] - 4'd1;
                    end else begin
                        outst_d[n] = 4'd0;
                    end
                end
                default: outst_d[n] = outst_q[n];
            endcase

            if (reqValid[n] && !accept_s[n]) begin
                if (wait_q[n] == STARVE_L) begin
                    wait_d[n] = STARVE_L;
                end else begin
                    wait_d[n] = wait_q[n] + 8'd1;
                end
            end else begin
                wait_d[n] = 8'd0;
            end
        end
        // Strobe follows the counters in the same cycle they saturate.
        deadlock_d = (wait_d[0] == STARVE_L) || (wait_d[1] == STARVE_L);
    end

    // Pointer moves to the other port after every grant.
    always_comb begin
        if (gnt_valid_s) begin
            rr_d = ~gnt_idx_s;
        end else begin
            rr_d = rr_q;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            ring_seq_q  <= 16'h0000;
            ring_opm_q  <= 16'h0000;
            ring_addr_q <= 48'h0;
            ring_data_q <= 128'h0;
            rsp_valid_q <= 2'b00;
            rsp_seq_q   <= '{default: 16'h0000};
            rsp_opm_q   <= '{default: 16'h0000};
            rsp_addr_q  <= '{default: 48'h0};
            rsp_data_q  <= '{default: 128'h0};
            seq_ctr_q   <= '{default: 8'h01};
            outst_q     <= '{default: 4'd0};
            wait_q      <= '{default: 8'd0};
            rr_q        <= 1'b0;
            deadlock_q  <= 1'b0;
        end else begin
            ring_seq_q  <= ring_seq_d;
            ring_opm_q  <= ring_opm_d;
            ring_addr_q <= ring_addr_d;
            ring_data_q <= ring_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_seq_q   <= rsp_seq_d;
            rsp_opm_q   <= rsp_opm_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
            seq_ctr_q   <= seq_ctr_d;
            outst_q     <= outst_d;
            wait_q      <= wait_d;
            rr_q        <= rr_d;
            deadlock_q  <= deadlock_d;
        end
    end

    assign memSeqOut      = ring_seq_q;
    assign memOpmOut      = ring_opm_q;
    assign memAddrOut     = ring_addr_q;
    assign memDataOut     = ring_data_q;
    assign rspValid       = rsp_valid_q;
    assign rspSeq         = rsp_seq_q;
    assign rspOpm         = rsp_opm_q;
    assign rspAddr        = rsp_addr_q;
    assign rspData        = rsp_data_q;
    assign deadlockStrobe = deadlock_q;

endmodule

// File: tb/tb_rbi_ring_req_arb.sv
module tb_rbi_ring_req_arb;

    logic               clock = 1'b0;
    logic               reset;
    logic [7:0]         unitNodeId;
    logic [15:0]        memSeqIn, memOpmIn, memSeqOut, memOpmOut;
    logic [47:0]        memAddrIn, memAddrOut;
    logic [127:0]       memDataIn, memDataOut;
    logic [1:0]         reqValid, reqReady, rspValid;
    logic [1:0][15:0]   reqOpm, rspSeq, rspOpm;
    logic [1:0][47:0]   reqAddr, rspAddr;
    logic [1:0][127:0]  reqData, rspData;
    logic               deadlockStrobe;

    always #5 clock = ~clock;

    rbi_ring_req_arb #(.MAX_OUTST(4), .STARVE_LIM(8)) dut (
        .clock(clock), .reset(reset), .unitNodeId(unitNodeId),
        .memSeqIn(memSeqIn), .memOpmIn(memOpmIn), .memAddrIn(memAddrIn), .memDataIn(memDataIn),
        .memSeqOut(memSeqOut), .memOpmOut(memOpmOut), .memAddrOut(memAddrOut), .memDataOut(memDataOut),
        .reqValid(reqValid), .reqReady(reqReady), .reqOpm(reqOpm), .reqAddr(reqAddr), .reqData(reqData),
        .rspValid(rspValid), .rspSeq(rspSeq), .rspOpm(rspOpm), .rspAddr(rspAddr), .rspData(rspData),
        .deadlockStrobe(deadlockStrobe)
    );

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] D0 = 128'h0000_0000_0000_0000_0000_0000_0000_D0D0;
    localparam logic [127:0] D1 = 128'h0000_0000_0000_0000_0000_0000_0000_D1D1;

    typedef struct {
        logic [15:0] seq_in;
        logic [15:0] opm_in;
        logic [47:0] addr_in;
        logic [1:0]  valid;
        logic [1:0]  exp_ready;
        logic [15:0] exp_seq;
        logic [15:0] exp_opm;
        logic [47:0] exp_addr;
        logic [1:0]  exp_rsp;
    } vec_t;

    vec_t tbl [11];

    function automatic logic [127:0] ring_data(input logic [15:0] s, input logic [15:0] o,
                                               input logic [47:0] a);
        return {s, o, a, 48'h5A5A_5A5A_5A5A};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ring_in(input logic [15:0] s, input logic [15:0] o, input logic [47:0] a,
                           input logic [1:0] v);
        @(negedge clock);
        memSeqIn  = s;
        memOpmIn  = o;
        memAddrIn = a;
        memDataIn = ring_data(s, o, a);
        reqValid  = v;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        memSeqIn  = 16'h0000;
        memOpmIn  = 16'h0000;
        memAddrIn = 48'h0;
        memDataIn = 128'h0;
        reqValid  = 2'b11;
        #1 chk("ready_in_reset", 128'(reqReady), 128'(2'b00));
        @(posedge clock);
        #1;
        chk("reset_seq_out", 128'(memSeqOut), 128'h0);
        chk("reset_data_out", memDataOut, 128'h0);
        chk("reset_rsp_valid", 128'(rspValid), 128'h0);
        chk("reset_deadlock", 128'(deadlockStrobe), 128'h0);
        @(negedge clock);
        reset    = 1'b0;
        reqValid = 2'b00;
    endtask

    initial begin
        logic [127:0] exp_data;
        logic [7:0]   tag;

        reset      = 1'b1;
        unitNodeId = 8'h82;
        memSeqIn   = 16'h0000;
        memOpmIn   = 16'h0000;
        memAddrIn  = 48'h0;
        memDataIn  = 128'h0;
        reqValid   = 2'b00;
        reqOpm[0]  = 16'h0093;
        reqOpm[1]  = 16'h00A3;
        reqAddr[0] = 48'h1000;
        reqAddr[1] = 48'h2000;
        reqData[0] = D0;
        reqData[1] = D1;

        //          seq_in    opm_in    addr_in  valid  ready  exp_seq   exp_opm   exp_addr  rsp
        tbl[0]  = '{16'h0000, 16'h0000, 48'h0,   2'b01, 2'b01, 16'h8201, 16'h0093, 48'h1000, 2'b00};
        tbl[1]  = '{16'h0000, 16'h0000, 48'h0,   2'b11, 2'b10, 16'h8301, 16'h00A3, 48'h2000, 2'b00};
        tbl[2]  = '{16'h0000, 16'h0000, 48'h0,   2'b11, 2'b01, 16'h8202, 16'h0093, 48'h1000, 2'b00};
        tbl[3]  = '{16'h0000, 16'h0000, 48'h0,   2'b11, 2'b10, 16'h8302, 16'h00A3, 48'h2000, 2'b00};
        tbl[4]  = '{16'h4001, 16'h0093, 48'hABC, 2'b01, 2'b00, 16'h4001, 16'h0093, 48'hABC,  2'b00};
        tbl[5]  = '{16'h8305, 16'h0053, 48'h2000, 2'b00, 2'b00, 16'h0000, 16'h0000, 48'h0,   2'b10};
        tbl[6]  = '{16'h8207, 16'h0053, 48'h1000, 2'b11, 2'b01, 16'h8203, 16'h0093, 48'h1000, 2'b01};
        tbl[7]  = '{16'h0000, 16'h0000, 48'h0,   2'b00, 2'b00, 16'h0000, 16'h0000, 48'h0,    2'b00};
        tbl[8]  = '{16'h8405, 16'h0053, 48'h777, 2'b10, 2'b00, 16'h8405, 16'h0053, 48'h777,  2'b00};
        tbl[9]  = '{16'h0000, 16'h0000, 48'h0,   2'b10, 2'b10, 16'h8303, 16'h00A3, 48'h2000, 2'b00};
        tbl[10] = '{16'h1234, 16'h5500, 48'h9,   2'b01, 2'b01, 16'h8204, 16'h0093, 48'h1000, 2'b00};

        do_reset();

        // Table-driven sequence from the reset state.
        for (int i = 0; i < 11; i++) begin
            ring_in(tbl[i].seq_in, tbl[i].opm_in, tbl[i].addr_in, tbl[i].valid);
            #1 chk($sformatf("v%0d_ready", i), 128'(reqReady), 128'(tbl[i].exp_ready));
            @(posedge clock);
            #1;
            if (tbl[i].exp_ready[0]) begin
                exp_data = D0;
            end else if (tbl[i].exp_ready[1]) begin
                exp_data = D1;
            end else if (tbl[i].exp_opm != 16'h0000) begin
                exp_data = ring_data(tbl[i].seq_in, tbl[i].opm_in, tbl[i].addr_in);
            end else begin
                exp_data = 128'h0;
            end
            chk($sformatf("v%0d_seq_out", i), 128'(memSeqOut), 128'(tbl[i].exp_seq));
            chk($sformatf("v%0d_opm_out", i), 128'(memOpmOut), 128'(tbl[i].exp_opm));
            chk($sformatf("v%0d_addr_out", i), 128'(memAddrOut), 128'(tbl[i].exp_addr));
            chk($sformatf("v%0d_data_out", i), memDataOut, exp_data);
            chk($sformatf("v%0d_rsp_valid", i), 128'(rspValid), 128'(tbl[i].exp_rsp));
        end
        chk("rsp1_seq", 128'(rspSeq[1]), 128'h8305);
        chk("rsp1_opm", 128'(rspOpm[1]), 128'h0053);
        chk("rsp1_addr", 128'(rspAddr[1]), 128'h2000);
        chk("rsp1_data", rspData[1], ring_data(16'h8305, 16'h0053, 48'h2000));
        chk("rsp0_seq", 128'(rspSeq[0]), 128'h8207);

        // Outstanding limit: four accepts, then blocked until a response returns.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            ring_in(16'h0000, 16'h0000, 48'h0, 2'b01);
            #1 chk($sformatf("lim%0d_ready", i), 128'(reqReady), (i < 4) ? 128'(2'b01) : 128'h0);
            @(posedge clock);
            #1 chk($sformatf("lim%0d_seq_out", i), 128'(memSeqOut),
                   (i < 4) ? 128'({8'h82, 8'(i + 1)}) : 128'h0);
        end
        ring_in(16'h8201, 16'h0053, 48'h1000, 2'b01);
        #1 chk("lim_mine_ready", 128'(reqReady), 128'h0);
        @(posedge clock);
        #1;
        chk("lim_mine_rsp_valid", 128'(rspValid), 128'(2'b01));
        chk("lim_mine_rsp_seq", 128'(rspSeq[0]), 128'h8201);
        chk("lim_mine_ring_out", 128'(memSeqOut), 128'h0);
        ring_in(16'h0000, 16'h0000, 48'h0, 2'b01);
        #1 chk("lim_fifth_ready", 128'(reqReady), 128'(2'b01));
        @(posedge clock);
        #1;
        chk("lim_fifth_seq_out", 128'(memSeqOut), 128'h8205);
        chk("lim_rsp_strobe_drop", 128'(rspValid), 128'h0);

        // Starvation behind continuous PASS traffic (limit 8 in this instance).
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            ring_in(16'h4001, 16'h0093, 48'hABC, 2'b10);
            #1 chk($sformatf("stv%0d_ready", i), 128'(reqReady), 128'h0);
            @(posedge clock);
            #1 chk($sformatf("stv%0d_deadlock", i), 128'(deadlockStrobe), (i >= 8) ? 128'h1 : 128'h0);
        end
        ring_in(16'h4001, 16'h0093, 48'hABC, 2'b00);
        @(posedge clock);
        #1 chk("stv_clear_deadlock", 128'(deadlockStrobe), 128'h0);

        // Tag wrap: every slot is a response for port 0, so outstanding stays 0.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            ring_in(16'h8200, 16'h0053, 48'h1000, 2'b01);
            #1 chk($sformatf("wrap%0d_ready", i), 128'(reqReady), 128'(2'b01));
            @(posedge clock);
            tag = 8'((i % 255) + 1);
            #1 chk($sformatf("wrap%0d_seq_out", i), 128'(memSeqOut), 128'({8'h82, tag}));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
